usb_tx_encoder: RTL

USB full-speed style transmit encoder. It accepts packet bytes over a valid/ready handshake and serialises them LSB-first behind an automatic SYNC byte. It applies bit stuffing and NRZI encoding, then terminates each packet with an EOP. It drives the d_plus/d_minus line pair toward the bus and is the transmit-side counterpart of the receive-path NRZI decoder.

---
 rtl/usb_tx_encoder.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB FS transmit encoder: SYNC, bit stuffing, NRZI, EOP; CRC16 tail when USB_TX_CRC16_EN is defined
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = $clog2(STUFF_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef USB_TX_CRC16_EN
    CRC,
`endif
    EOP_SE0,
    EOP_J
  } state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;     // index of the last real bit put on the line, or EOP bit-time count
  logic [SW-1:0] stuff_cnt;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic          hold_full;
  logic          last_acc;    // a byte flagged last has been taken for this packet
  logic [7:0]    shift_reg;
  logic          shift_last;
  logic          aborted;
`ifdef USB_TX_CRC16_EN
  logic [15:0]   crc;
  logic [15:0]   crc_upd;
`endif

  logic wrap;
  logic stuff_now;
  logic byte_end;
  logic nxt_bit;
  logic to_eop;
  logic underrun;

  assign tx_ready = !rst && !hold_full && !last_acc &&
                    (state == IDLE || state == SYNC || state == DATA);
  assign wrap     = (bit_cnt == CW'(CLKS_PER_BIT - 1));

  // Decide what the next bit time carries: stuffed 0, next stream bit, or end of packet
  always_comb begin
    stuff_now = (stuff_cnt == SW'(STUFF_LIMIT));
    byte_end  = (bit_idx == 4'd7);
    nxt_bit   = 1'b0;
    to_eop    = 1'b0;
    underrun  = 1'b0;
    case (state)
      SYNC: nxt_bit = byte_end ? hold_data[0] : (bit_idx == 4'd6);
      DATA: begin
        if (!byte_end) begin
          nxt_bit = shift_reg[1];
        end else if (shift_last) begin
`ifdef USB_TX_CRC16_EN
          nxt_bit = ~crc[0];
`else
          to_eop = 1'b1;
`endif
        end else if (hold_full) begin
          nxt_bit = hold_data[0];
        end else begin
          to_eop   = 1'b1;
          underrun = 1'b1;
        end
      end
`ifdef USB_TX_CRC16_EN
      CRC: begin
        if (bit_idx == 4'd15) to_eop = 1'b1;
        else                  nxt_bit = crc[1];
      end
`endif
      default: ;
    endcase
    if (stuff_now) begin
      nxt_bit  = 1'b0;
      to_eop   = 1'b0;
      underrun = 1'b0;
    end
`ifdef USB_TX_CRC16_EN
    crc_upd = {1'b0, crc[15:1]} ^ ((crc[0] ^ nxt_bit) ? 16'hA001 : 16'h0000);
`endif
  end

  // Packet FSM, bit timing, line drive and holding-register handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= 4'd0;
      stuff_cnt  <= '0;
      hold_data  <= 8'h00;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      last_acc   <= 1'b0;
      shift_reg  <= 8'h00;
      shift_last <= 1'b0;
      aborted    <= 1'b0;
      d_plus     <= 1'b1;
      d_minus    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc        <= 16'hFFFF;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (state == IDLE) begin
        if (tx_valid && tx_ready) begin
          state     <= SYNC;
          bit_cnt   <= '0;
          bit_idx   <= 4'd0;
          stuff_cnt <= '0;
          aborted   <= 1'b0;
          tx_busy   <= 1'b1;
          d_plus    <= 1'b0;   // first SYNC bit is 0: J -> K
          d_minus   <= 1'b1;
`ifdef USB_TX_CRC16_EN
          crc       <= 16'hFFFF;
`endif
        end
      end else if (!wrap) begin
        bit_cnt <= bit_cnt + CW'(1);
      end else begin
        bit_cnt <= '0;
        case (state)
          EOP_SE0: begin
            if (bit_idx == 4'd1) begin
              state   <= EOP_J;
              d_plus  <= 1'b1;
              d_minus <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          EOP_J: begin
            state     <= IDLE;
            tx_busy   <= 1'b0;
            tx_done   <= !aborted;
            hold_full <= 1'b0;
            last_acc  <= 1'b0;
            bit_idx   <= 4'd0;
          end
          default: begin
            if (to_eop) begin
              state   <= EOP_SE0;
              bit_idx <= 4'd0;
              d_plus  <= 1'b0;
              d_minus <= 1'b0;
              tx_err  <= underrun;
              aborted <= underrun;
            end else begin
              if (!nxt_bit) begin
                d_plus    <= ~d_plus;
                d_minus   <= ~d_minus;
                stuff_cnt <= '0;
              end else begin
                stuff_cnt <= stuff_cnt + SW'(1);
              end
              if (!stuff_now) begin
                case (state)
                  SYNC: begin
                    if (byte_end) begin
                      state      <= DATA;
                      bit_idx    <= 4'd0;
                      shift_reg  <= hold_data;
                      shift_last <= hold_last;
                      hold_full  <= 1'b0;
`ifdef USB_TX_CRC16_EN
                      crc        <= crc_upd;
`endif
                    end else begin
                      bit_idx <= bit_idx + 4'd1;
                    end
                  end
                  DATA: begin
                    if (!byte_end) begin
                      shift_reg <= {1'b0, shift_reg[7:1]};
                      bit_idx   <= bit_idx + 4'd1;
`ifdef USB_TX_CRC16_EN
                      crc       <= crc_upd;
`endif
                    end else if (shift_last) begin
`ifdef USB_TX_CRC16_EN
                      state   <= CRC;
                      bit_idx <= 4'd0;
                      crc     <= ~crc;
`endif
                    end else begin
                      bit_idx    <= 4'd0;
                      shift_reg  <= hold_data;
                      shift_last <= hold_last;
                      hold_full  <= 1'b0;
`ifdef USB_TX_CRC16_EN
                      crc        <= crc_upd;
`endif
                    end
                  end
`ifdef USB_TX_CRC16_EN
                  CRC: begin
                    crc     <= {1'b0, crc[15:1]};
                    bit_idx <= bit_idx + 4'd1;
                  end
`endif
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
        if (tx_last) last_acc <= 1'b1;
      end
    end
  end

endmodule
